// File: rtl/video_frame_sink_pkg.sv
// Shared video-core types: pixel stream record, frame geometry and sink FSM states.
package video_frame_sink_pkg;

    localparam int unsigned HSize = 640;
    localparam int unsigned VSize = 480;
    localparam int unsigned Rw    = 4;   // width of each colour channel
    localparam int unsigned HcW   = 10;
    localparam int unsigned VcW   = 10;

    // One pixel of the daisy-chain stream; start marks pixel (0,0).
    typedef struct packed {
        logic           start;
        logic [HcW-1:0] hc;
        logic [VcW-1:0] vc;
        logic [Rw-1:0]  r;
        logic [Rw-1:0]  g;
        logic [Rw-1:0]  b;
    } vga_frame_t;

    typedef enum logic [1:0] {
        StSync,
        StFill,
        StRun
    } sink_state_t;

endpackage

// File: rtl/video_frame_sink_if.sv
// Pixel stream handshake between the last chain stage (master) and the frame sink (slave).
interface video_frame_sink_if;
    import video_frame_sink_pkg::*;

    logic       source_vld;
    vga_frame_t source_frame;
    logic       stall;

    modport master (output source_vld, output source_frame, input stall);
    modport slave  (input source_vld, input source_frame, output stall);

endinterface

// File: rtl/video_sink_fifo.sv
// Synchronous FIFO with a 1-bit tag lane, registered read data and a same-cycle flush.
// A push coinciding with flush is kept as the sole entry of the emptied FIFO.
module video_sink_fifo #(
    parameter int unsigned DW    = 12,
    parameter int unsigned Depth = 16,
    localparam int unsigned AW   = $clog2(Depth),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic          tag_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          head_tag_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW:0]   mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_addr;
    logic [CW-1:0] count_q;
    logic [DW-1:0] dout_q;
    logic          wr_en, rd_en;

    assign full_o     = (count_q == CW'(Depth));
    assign empty_o    = (count_q == '0);
    assign wr_en      = push_i & (flush_i | ~full_o);
    assign rd_en      = pop_i & ~empty_o;
    assign wr_addr    = flush_i ? '0 : wr_ptr_q;
    // Tag of the entry the next pop will return, for checks before popping.
    assign head_tag_o = mem_q[rd_ptr_q][DW];
    assign dout_o     = dout_q;
    assign count_o    = count_q;

    // Pointer and occupancy tracking; flush restarts both pointers at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= wr_en ? AW'(1) : '0;
            rd_ptr_q <= '0;
            count_q  <= CW'(wr_en);
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(wr_en);
            rd_ptr_q <= rd_ptr_q + AW'(rd_en);
            count_q  <= count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= {tag_i, din_i};
        end
    end

    // Registered read port, holds between pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (rd_en) begin
            dout_q <= mem_q[rd_ptr_q][DW-1:0];
        end
    end

endmodule

// File: rtl/video_frame_sink.sv
// Terminal sink of the video chain: buffers the pixel stream, applies backpressure and
// replays pixels to the sync controller aligned on the frame start.
// Optional build macro: VIDEO_FRAME_SINK_STATS_EN enables the saturating underflow counter.
module video_frame_sink
    import video_frame_sink_pkg::*;
#(
    parameter int unsigned FifoDepth  = 16,
    parameter int unsigned AfullThres = FifoDepth - 3,
    parameter int unsigned Prefill    = FifoDepth / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    video_frame_sink_if.slave    src_if,
    input  logic                 pixel_req_i,
    input  logic                 sync_start_i,
    output logic [Rw-1:0]        vga_r_o,
    output logic [Rw-1:0]        vga_g_o,
    output logic [Rw-1:0]        vga_b_o,
    output logic                 resync_err_o,
    output logic [15:0]          underflow_cnt_o
);

    localparam int unsigned CntW  = $clog2(FifoDepth) + 1;
    localparam int unsigned DataW = 3 * Rw;

    sink_state_t      state_q, state_d;
    logic             stall_q, show_q, err_q;
    logic             push, push_eff, wr_ok, pop, flush;
    logic             underflow, misalign, overflow;
    logic [CntW-1:0]  count, cnt_next;
    logic             full, empty, head_tag;
    logic [DataW-1:0] data_in, data_out;

    assign data_in = {src_if.source_frame.r, src_if.source_frame.g, src_if.source_frame.b};

    video_sink_fifo #(
        .DW    (DataW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_eff),
        .pop_i      (pop),
        .flush_i    (flush),
        .tag_i      (src_if.source_frame.start),
        .din_i      (data_in),
        .dout_o     (data_out),
        .head_tag_o (head_tag),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty)
    );

    // Next state, FIFO control and error events.
    always_comb begin
        push      = src_if.source_vld & ~stall_q &
                    ((state_q != StSync) | src_if.source_frame.start);
        pop       = 1'b0;
        flush     = 1'b0;
        underflow = 1'b0;
        misalign  = 1'b0;
        state_d   = state_q;
        unique case (state_q)
            StSync: flush = 1'b1;
            StFill: begin
                if (pixel_req_i && sync_start_i && (count >= CntW'(Prefill))) begin
                    pop     = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (pixel_req_i) begin
                    if (empty) begin
                        underflow = 1'b1;
                        flush     = 1'b1;
                        state_d   = StSync;
                    end else begin
                        pop = 1'b1;
                        if (head_tag ^ sync_start_i) begin
                            misalign = 1'b1;
                            flush    = 1'b1;
                            state_d  = StSync;
                        end
                    end
                end
            end
            default: state_d = StSync;
        endcase
        // While flushing only a frame-start pixel survives; it restarts the fill.
        push_eff = push & (~flush | src_if.source_frame.start);
        if (flush && push_eff) begin
            state_d = StFill;
        end
        wr_ok    = push_eff & (flush | ~full);
        overflow = push_eff & full & ~flush;
        cnt_next = flush ? CntW'(wr_ok) : count + CntW'(wr_ok) - CntW'(pop);
    end

    // FSM state plus registered stall, output-enable and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StSync;
            stall_q <= 1'b0;
            show_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= (cnt_next >= CntW'(AfullThres));
            if (state_d != StRun) begin
                show_q <= 1'b0;
            end else if (pixel_req_i) begin
                show_q <= pop;
            end
            if (underflow || misalign || overflow) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef VIDEO_FRAME_SINK_STATS_EN
    logic [15:0] uf_cnt_q;

    // Saturating count of underflow events.
    always_ff @(posedge clk) begin
        if (rst) begin
            uf_cnt_q <= '0;
        end else if (underflow && (uf_cnt_q != 16'hffff)) begin
            uf_cnt_q <= uf_cnt_q + 16'd1;
        end
    end

    assign underflow_cnt_o = uf_cnt_q;
`else
    assign underflow_cnt_o = '0;
`endif

    assign src_if.stall = stall_q;
    assign resync_err_o = err_q;
    assign vga_r_o      = show_q ? data_out[3*Rw-1:2*Rw] : '0;
    assign vga_g_o      = show_q ? data_out[2*Rw-1:Rw]   : '0;
    assign vga_b_o      = show_q ? data_out[Rw-1:0]      : '0;

endmodule

// File: tb/tb_video_frame_sink.sv
// Randomized bench for video_frame_sink against a queue-based model of the sink behaviour.
module tb_video_frame_sink;
    import video_frame_sink_pkg::*;

    localparam int unsigned Depth    = 16;
    localparam int unsigned Afull    = Depth - 3;
    localparam int unsigned Prefill  = Depth / 2;
    localparam int unsigned FramePix = 64;   // 8x8 test frame keeps the run short
    localparam int unsigned Cw3      = 3 * Rw;

    logic          clk = 1'b0;
    logic          rst;
    logic          pixel_req, sync_start;
    logic [Rw-1:0] vga_r, vga_g, vga_b;
    logic          resync_err;
    logic [15:0]   underflow_cnt;

    always #5 clk = ~clk;

    video_frame_sink_if src_if ();

    video_frame_sink #(
        .FifoDepth (Depth)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .src_if          (src_if),
        .pixel_req_i     (pixel_req),
        .sync_start_i    (sync_start),
        .vga_r_o         (vga_r),
        .vga_g_o         (vga_g),
        .vga_b_o         (vga_b),
        .resync_err_o    (resync_err),
        .underflow_cnt_o (underflow_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of {start, rgb} entries and a playback mode.
    typedef enum int {MdSync, MdFill, MdRun} mode_t;
    typedef struct packed {
        logic           start;
        logic [Cw3-1:0] rgb;
    } ent_t;

    ent_t           q[$];
    mode_t          m_mode = MdSync;
    bit             m_stall = 1'b0;
    bit             m_err = 1'b0;
    int             m_uf = 0;
    logic [Cw3-1:0] m_rgb = '0;

    int up_idx  = 37;   // upstream starts mid-frame
    int ctl_idx = 0;
    int cyc     = 0;

    function automatic logic [Cw3-1:0] color(input int p);
        return Cw3'(p * 29 + 5);
    endfunction

    task automatic model_push(input bit acc, input bit full, input bit st,
                              input logic [Cw3-1:0] rgb);
        if (acc) begin
            if (full) m_err = 1'b1;
            else q.push_back('{start: st, rgb: rgb});
        end
    endtask

    task automatic model_step(input bit r, input bit v, input bit st, input logic [Cw3-1:0] rgb,
                              input bit pr, input bit ss);
        int   sz0;
        bit   acc, full, leave;
        ent_t e;
        if (r) begin
            q.delete();
            m_mode  = MdSync;
            m_stall = 1'b0;
            m_err   = 1'b0;
            m_uf    = 0;
            m_rgb   = '0;
            return;
        end
        sz0   = q.size();
        full  = (sz0 == Depth);
        acc   = v && !m_stall && (m_mode != MdSync || st);
        leave = 1'b0;
        if (m_mode == MdSync) begin
            if (acc) begin
                q.push_back('{start: st, rgb: rgb});
                m_mode = MdFill;
            end
        end else if (m_mode == MdFill) begin
            if (pr && ss && sz0 >= Prefill) begin
                e      = q.pop_front();
                m_rgb  = e.rgb;
                m_mode = MdRun;
            end
            model_push(acc, full, st, rgb);
        end else begin
            if (pr) begin
                if (sz0 == 0) begin
                    leave = 1'b1;
`ifdef VIDEO_FRAME_SINK_STATS_EN
                    if (m_uf < 65535) m_uf++;
`endif
                end else begin
                    e     = q.pop_front();
                    m_rgb = e.rgb;
                    if (e.start != ss) leave = 1'b1;
                end
            end
            if (leave) begin
                m_err = 1'b1;
                q.delete();
                m_mode = MdSync;
                if (acc && st) begin
                    q.push_back('{start: st, rgb: rgb});
                    m_mode = MdFill;
                end
            end else begin
                model_push(acc, full, st, rgb);
            end
        end
        if (m_mode != MdRun) m_rgb = '0;
        m_stall = (q.size() >= Afull);
    endtask

    task automatic compare_outputs();
        check_eq("stall", 32'(src_if.stall), 32'(m_stall));
        check_eq("rgb", 32'({vga_r, vga_g, vga_b}), 32'(m_rgb));
        check_eq("resync_err", 32'(resync_err), 32'(m_err));
        check_eq("underflow_cnt", 32'(underflow_cnt), 32'(m_uf));
        check_eq("fifo_count", 32'(dut.u_fifo.count_o), 32'(q.size()));
    endtask

    // One clock: drive at negedge, step the model at posedge, compare at the next negedge.
    task automatic tick(input bit r, input bit v, input bit pr, input bit skip);
        bit             ss, st, stall_seen;
        logic [Cw3-1:0] rgb;
        if (skip) ctl_idx++;
        ss  = pr && (ctl_idx % FramePix == 0);
        st  = (up_idx % FramePix == 0);
        rgb = color(up_idx);
        rst = r;
        src_if.source_vld         = v;
        src_if.source_frame.start = st;
        src_if.source_frame.hc    = HcW'(up_idx % 8);
        src_if.source_frame.vc    = VcW'((up_idx / 8) % 8);
        src_if.source_frame.r     = rgb[3*Rw-1:2*Rw];
        src_if.source_frame.g     = rgb[2*Rw-1:Rw];
        src_if.source_frame.b     = rgb[Rw-1:0];
        pixel_req  = pr;
        sync_start = ss;
        stall_seen = src_if.stall;
        @(posedge clk);
        model_step(r, v, st, rgb, pr, ss);
        if (v && !stall_seen) up_idx++;
        if (pr) ctl_idx++;
        cyc++;
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run_normal(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, $urandom_range(3, 0) != 0, (cyc % 4) == 0, 1'b0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        pixel_req  = 1'b0;
        sync_start = 1'b0;
        src_if.source_vld   = 1'b0;
        src_if.source_frame = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);

        // Mid-frame start, fill, then steady playback.
        run_normal(1500);

        // No requests with input always valid: occupancy climbs to the stall threshold.
        for (int i = 0; i < 60; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        // A single request releases stall one cycle later.
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        run_normal(200);

        // Starve the FIFO until requests underflow, then recover.
        for (int i = 0; i < 200; i++) tick(1'b0, 1'b0, (cyc % 4) == 0, 1'b0);
        run_normal(800);

        // Controller jumps one pixel ahead: early sync_start, realign next frame.
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        run_normal(800);

        // Irregular request and valid patterns.
        for (int i = 0; i < 1500; i++) begin
            tick(1'b0, $urandom_range(9, 0) < 6, $urandom_range(9, 0) < 3, 1'b0);
        end
        run_normal(300);

        // Reset mid-playback with entries buffered.
        for (int i = 0; i < 40 && q.size() < 10; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        run_normal(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_frame_sink.md
# video_frame_sink

Terminal consumer of the video-core daisy chain. Accepts the `vga_frame_t` pixel stream (`source_vld`/`source_frame`), buffers it in a small synchronous FIFO, and drives the chain's `stall` input as backpressure. Pixels are replayed to the VGA sync controller on its per-pixel request, aligned so that the `start` pixel lands exactly on the controller's first visible pixel. Lost alignment and underflow are detected and recovered automatically.

## Interface
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of 2, minimum 8.
- `AFULL_THRES`, FIFO_DEPTH-3: count at or above which `stall` is asserted.
- `PREFILL`, FIFO_DEPTH/2: minimum count required before playback starts.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `source_vld`  in  1  upstream pixel valid. Consumed only when `stall`=0.
- `source_frame`  in  vga_frame_t  upstream pixel; `start` marks pixel (0,0).
- `stall`  out  1  backpressure to every chain stage and the frame counter.
- `pixel_req`  in  1  sync controller wants one pixel this cycle (display-active tick).
- `sync_start`  in  1  asserted together with `pixel_req` for the first visible pixel of a frame.
- `vga_r`/`vga_g`/`vga_b`  out  RW each  registered pixel colour; RW is the width of the `vga_frame_t` r/g/b fields.
- `resync_err`  out  1  sticky; set on any alignment loss or underflow; cleared only by reset.
- `underflow_cnt`  out  16  see Configuration.

## Operation
- Write: `push = source_vld & ~stall & (state != SYNC | source_frame.start)`. The FIFO entry is `{start, r, g, b}`; `hc`/`vc` are not stored.
- Push while full: the pixel is dropped and `resync_err` is set. This cannot happen while the thresholds are respected.
- Count: push and pop in the same cycle leave the count unchanged.
- State machine, reset state SYNC:
  - SYNC: FIFO flushed. Input is discarded until a pushed pixel has `start`=1, then go to FILL.
  - FILL: no pops. Outputs are black. When `pixel_req & sync_start & count>=PREFILL`, pop the head (it must be the start pixel) and go to RUN.
  - RUN: pop on every `pixel_req`.
    - Popped entry has `start` XOR `sync_start`: set `resync_err` and go to SYNC.
    - `pixel_req` while empty: output black, set `resync_err`, increment the underflow counter, go to SYNC.
- Leaving RUN for SYNC flushes the FIFO in that same cycle. Any simultaneous push is discarded unless it carries `start`=1, in which case it is kept and the next state is FILL.
- Outputs are black (all zero) whenever the state is not RUN or no pop occurs on a `pixel_req`. Between requests, the RGB output holds its last value.

## Timing
- Reset values: `stall`=0, RGB=0, `resync_err`=0, `underflow_cnt`=0, count=0, state SYNC.
- `stall` is registered: `stall(n+1) = count_next(n) >= AFULL_THRES`. The 1-cycle lag is absorbed by the 3-entry margin.
- Read latency: `pixel_req` in cycle n gives RGB valid from cycle n+1.
- Write-to-read: a pixel pushed in cycle n is poppable from cycle n+1. There is no fall-through.
- `stall` is never forced high in SYNC or FILL. Upstream free-runs while searching for `start`.

## Configuration
- `VIDEO_FRAME_SINK_STATS_EN` defined:
  - `underflow_cnt` counts underflow events.
  - The counter saturates at 0xFFFF.
  - It is reset to 0 by `rst`.
- Undefined: `underflow_cnt` is tied to 0 and no counter logic is built. `resync_err` is always present.

## Structure
- `vga_frame_t`, `H_SIZE`/`V_SIZE` and the RGB widths come from the shared `vga.svh`.
- Add the state enum `sink_state_t` (SYNC/FILL/RUN) to that shared header.
- Sub-module `video_sink_fifo`:
  - synchronous FIFO with parameters DW and depth;
  - ports push, pop, flush, din, dout, count, full, empty;
  - registered dout.
- The FSM, stall generation and error logic live in `video_frame_sink`.

## Test plan
- Reset, then a stream starting mid-frame (hc=100): no push until `start`=1; state becomes FILL; `stall`=0 throughout.
- Steady state, 640x480 stream, `pixel_req` every 4th cycle:
  - `stall` toggles and count never exceeds FIFO_DEPTH;
  - output pixel (0,0) appears 1 cycle after `sync_start`;
  - `resync_err`=0.
- Fill to count=13 (AFULL_THRES with DEPTH=16): `stall`=1 on the next cycle. A single pop to count=12 releases `stall` the following cycle.
- Withhold input during RUN until empty, then `pixel_req`:
  - RGB=0 and `resync_err`=1;
  - `underflow_cnt`=1 with STATS_EN, 0 without;
  - state SYNC, then recovery at the next `start`.
- Inject `sync_start` one pixel early during RUN: `resync_err`=1, FIFO flushed, playback realigned on the next frame.
- Assert `rst` mid-RUN with 10 entries held: all outputs return to their reset values on the next cycle and the FIFO is empty.
